// File: rtl/mac_pkg.sv
// Shared constants, state encoding and sizing helper for the MAC dot-product sequencer.
package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 16;

  // Sequencer FSM encoding, kept as plain constants so checkers can bind to raw bits.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_FEED  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_HOLD  = 3'd4;

  // Element counter must be able to hold VEC_LEN itself after the last increment.
  function automatic int cnt_width(input int vec_len);
    return (vec_len < 1) ? 1 : $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Bundle of the operand stream, the mac_top drive/return signals and the result stream.
//
// Handshake semantics (both streams): a transfer happens at a rising edge where
// valid && ready are both 1. The producer holds valid and payload stable until that
// edge; ready may change freely and never depends combinationally on valid.
interface mac_dot_sequencer_if
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic              mac_enable;
  logic              mac_clear;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_result;
  logic              mac_overflow;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_result;
  logic              out_overflow;

  logic              busy;

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, mac_result, mac_overflow, out_ready,
    output in_ready, mac_enable, mac_clear, mac_a, mac_b,
           out_valid, out_result, out_overflow, busy
  );

  // Environment side: operand producer, mac_top and result consumer.
  modport master (
    output in_valid, in_a, in_b, mac_result, mac_overflow, out_ready,
    input  in_ready, mac_enable, mac_clear, mac_a, mac_b,
           out_valid, out_result, out_overflow, busy
  );

endinterface

// File: rtl/mac_operand_fifo.sv
// Synchronous operand FIFO. No write-to-read bypass: data written at an edge is
// visible on dout from the following cycle. Head is read straight from storage.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 2 * MAC_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset flushes the FIFO without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds buffered operand pairs into mac_top, VEC_LEN at a time, and returns each
// finished dot product (plus an overflow flag for that vector) on a result stream.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = MAC_DATA_W,
  parameter int ACC_W      = MAC_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_dot_sequencer_if.slave   bus,
  output state_t               dbg_state_o
);

  localparam int CNT_W = cnt_width(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_result_q, out_result_d;
  logic               out_ovf_q, out_ovf_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*DATA_W-1:0] fifo_dout;
  logic               feeding;

  assign fifo_push = bus.in_valid && !fifo_full;

  mac_operand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2 * DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bus.in_a, bus.in_b}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A pair reaches the accumulator only when one is actually buffered, so an
  // empty FIFO in FEED stalls instead of adding a bubble.
  assign feeding  = (state_q == ST_FEED) && !fifo_empty;
  assign fifo_pop = feeding;

  assign bus.in_ready     = !fifo_full;
  assign bus.mac_enable   = feeding;
  assign bus.mac_clear    = (state_q == ST_CLEAR);
  assign bus.mac_a        = feeding ? fifo_dout[2*DATA_W-1:DATA_W] : '0;
  assign bus.mac_b        = feeding ? fifo_dout[DATA_W-1:0]        : '0;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign dbg_state_o      = state_q;

  // Next-state logic for the sequencer FSM, element counter, overflow latch and result register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        ovf_d = ovf_q | bus.mac_overflow;
        if (feeding) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The last add is visible on mac_result/mac_overflow in this cycle.
        out_result_d = bus.mac_result;
        out_ovf_d    = ovf_q | bus.mac_overflow;
        out_valid_d  = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = fifo_empty ? ST_IDLE : ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural mac_top model, operand and result scoreboards,
// directed vectors with hand-computed dot products.
module tb_mac_dot_sequencer;
  import mac_pkg::*;

  localparam int VEC_LEN    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int DW         = 8;
  localparam int AW         = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_sequencer_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
  state_t dbg_state;

  mac_dot_sequencer #(
    .VEC_LEN    (VEC_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DW),
    .ACC_W      (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- mac_top model (mod 2^16, sticky overflow) ----------------
  logic [AW-1:0] acc_q;
  logic          acc_ovf_q;
  logic [AW:0]   mac_sum;

  always_comb mac_sum = {1'b0, acc_q} + {1'b0, AW'(bus.mac_a) * AW'(bus.mac_b)};

  always @(posedge clk) begin
    if (rst || bus.mac_clear) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else if (bus.mac_enable) begin
      acc_q     <= mac_sum[AW-1:0];
      acc_ovf_q <= acc_ovf_q | mac_sum[AW];
    end
  end

  assign bus.mac_result   = acc_q;
  assign bus.mac_overflow = acc_ovf_q;

  // ---------------- scoreboard ----------------
  logic [2*DW-1:0] exp_q[$];   // operand pairs in acceptance order
  logic [AW:0]     res_q[$];   // {overflow, result} per vector
  logic [2*DW-1:0] exp_op;
  logic [AW:0]     exp_res;
  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      res_q.delete();
    end
  end

  // Monitor: operand stream into mac_top and the result stream, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mac_enable) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL operand_unexpected: got a=%0d b=%0d expected none", bus.mac_a, bus.mac_b);
        end else begin
          exp_op = exp_q.pop_front();
          chk("mac_a", 32'(bus.mac_a), 32'(exp_op[2*DW-1:DW]));
          chk("mac_b", 32'(bus.mac_b), 32'(exp_op[DW-1:0]));
        end
      end else begin
        chk("mac_a_idle", 32'(bus.mac_a), 32'd0);
        chk("mac_b_idle", 32'(bus.mac_b), 32'd0);
      end
      if (bus.mac_clear) clr_cnt++;
      chk("clear_enable_excl", 32'(bus.mac_clear & bus.mac_enable), 32'd0);
      if (bus.out_valid && !prev_valid) rise_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got %0d expected none", bus.out_result);
        end else begin
          exp_res = res_q.pop_front();
          chk("out_result", 32'(bus.out_result), 32'(exp_res[AW-1:0]));
          chk("out_overflow", 32'(bus.out_overflow), 32'(exp_res[AW]));
        end
      end
    end
    prev_valid = bus.out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, output int acc_cyc);
    logic done;
    done = 1'b0;
    acc_cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        exp_q.push_back({a, b});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (done) acc_cyc = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready expected accept for a=%0d b=%0d", a, b);
    end
    bus.in_valid = 1'b0;
  endtask

  // pv packs four pairs {a0,b0,a1,b1,a2,b2,a3,b3}; gap_len idle cycles before pair gap_at.
  task automatic send_vec(input logic [63:0] pv, input int gap_at, input int gap_len,
                          output int first_cyc);
    int c;
    first_cyc = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (i == gap_at) repeat (gap_len) begin @(posedge clk); #1; end
      send_pair(pv[(3-i)*16+8 +: 8], pv[(3-i)*16 +: 8], c);
      if (i == 0) first_cyc = c;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(posedge clk);
      #2;
      if (res_q.size() == 0 && exp_q.size() == 0 && !bus.busy && !bus.out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle", name, bus.busy, res_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] V153 = {8'd5, 8'd3, 8'd2, 8'd4, 8'd10, 8'd10, 8'd15, 8'd2};
  localparam logic [63:0] V30  = {8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4};
  localparam logic [63:0] V100 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [63:0] V16  = {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
  localparam logic [63:0] VOVF = {8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};

  int first_cyc, e0, c0, dummy;
  logic d_done;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    d_done        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_result", 32'(bus.out_result), 0);
    chk("rst_out_overflow", 32'(bus.out_overflow), 0);
    chk("rst_mac_enable", 32'(bus.mac_enable), 0);
    chk("rst_mac_clear", 32'(bus.mac_clear), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic vector: 15+8+100+30 = 153, latency VEC_LEN+3 edges
    res_q.push_back({1'b0, 16'd153});
    e0 = en_cnt; c0 = clr_cnt;
    send_vec(V153, -1, 0, first_cyc);
    wait_idle(100, "basic");
    chk("basic_latency", 32'(rise_cyc - first_cyc), 32'(VEC_LEN + 3));
    chk("basic_enables", 32'(en_cnt - e0), 32'(VEC_LEN));
    chk("basic_clears", 32'(clr_cnt - c0), 1);

    // Stall: 3 idle cycles before the third pair
    res_q.push_back({1'b0, 16'd153});
    e0 = en_cnt; c0 = clr_cnt;
    send_vec(V153, 2, 3, first_cyc);
    wait_idle(100, "stall");
    chk("stall_enables", 32'(en_cnt - e0), 32'(VEC_LEN));
    chk("stall_clears", 32'(clr_cnt - c0), 1);

    // Overflow: 2*65025 = 130050 -> 64514 mod 2^16
    res_q.push_back({1'b1, 16'd64514});
    send_vec(VOVF, -1, 0, first_cyc);
    wait_idle(100, "overflow");

    // Backpressure with full FIFO and a pending producer
    bus.out_ready = 1'b0;
    res_q.push_back({1'b0, 16'd153});
    res_q.push_back({1'b0, 16'd30});
    res_q.push_back({1'b0, 16'd100});
    res_q.push_back({1'b0, 16'd16});
    send_vec(V153, -1, 0, first_cyc);
    send_vec(V30, -1, 0, first_cyc);
    send_vec(V100, -1, 0, first_cyc);
    fork
      begin
        send_vec(V16, -1, 0, dummy);
        d_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_out_result", 32'(bus.out_result), 153);
      chk("hold_in_ready_full", 32'(bus.in_ready), 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_clear", 32'(bus.mac_clear), 1);
    chk("release_out_valid", 32'(bus.out_valid), 0);
    for (int t = 0; t < 300 && !d_done; t++) @(posedge clk);
    chk("producer_done", 32'(d_done), 1);
    wait_idle(200, "backpressure");

    // Reset mid-FEED, then a clean vector
    e0 = en_cnt;
    send_pair(8'd5, 8'd3, dummy);
    send_pair(8'd2, 8'd4, dummy);
    send_pair(8'd10, 8'd10, dummy);
    for (int t = 0; t < 50 && (en_cnt - e0) < 2; t++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_mac_enable", 32'(bus.mac_enable), 0);
    chk("midrst_mac_clear", 32'(bus.mac_clear), 0);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_result", 32'(bus.out_result), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_no_residue", 32'(bus.busy), 0);
    @(posedge clk); #1;
    res_q.push_back({1'b0, 16'd30});
    e0 = en_cnt;
    send_vec(V30, -1, 0, first_cyc);
    wait_idle(100, "after_reset");
    chk("after_reset_enables", 32'(en_cnt - e0), 32'(VEC_LEN));
    chk("final_operands_drained", 32'(exp_q.size()), 0);
    chk("final_results_drained", 32'(res_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Upstream feeder for mac_top. Buffers operand pairs arriving on a valid/ready stream and drives mac_top's enable/clear/a/b so that each group of VEC_LEN pairs becomes one dot product. Captures mac_top's result and overflow after the last pair of each vector and presents them on a valid/ready output.
mac_top contract:
- clear=1 zeroes the accumulator at the rising edge (clear wins over enable).
- enable=1 adds a*b at the rising edge.
- result/overflow reflect that edge from the next cycle.

Parameters:
VEC_LEN, 4, operand pairs per dot product (>=1)
FIFO_DEPTH, 8, operand FIFO entries (power of 2, >=2)
DATA_W, 8, operand width (matches mac_top a/b)
ACC_W, 16, result width (matches mac_top result)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (= !full)
in_a  in  DATA_W  operand a
in_b  in  DATA_W  operand b
mac_enable  out  1  to mac_top enable
mac_clear  out  1  to mac_top clear
mac_a  out  DATA_W  to mac_top a
mac_b  out  DATA_W  to mac_top b
mac_result  in  ACC_W  from mac_top result
mac_overflow  in  1  from mac_top overflow
out_valid  out  1  dot product available
out_ready  in  1  consumer accepts
out_result  out  ACC_W  captured dot product
out_overflow  out  1  overflow seen during this vector
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; FIFO flushed (count=0); element counter=0; ovf latch=0.
  - out_valid=0, out_result=0, out_overflow=0, mac_enable=0, mac_clear=0, mac_a=mac_b=0.
  - Reset mid-vector discards all buffered pairs and any partial or uncaptured result.
- FIFO:
  - Push on in_valid && in_ready; pop only in FEED.
  - No bypass: a pair pushed at edge E is poppable from the cycle after E.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Full: in_ready=0; a pop that cycle frees the slot from the next cycle.
- FSM states: IDLE, CLEAR, FEED, WAIT, HOLD.
  - IDLE: all mac outputs 0. FIFO non-empty -> CLEAR.
  - CLEAR (one cycle): mac_clear=1, mac_enable=0. Element counter and ovf latch zeroed. -> FEED.
  - FEED:
    - If FIFO non-empty: mac_enable=1, mac_a/mac_b = FIFO head (combinational from storage), pop, counter++.
    - If empty: mac_enable=0, counter holds (stall; no bubble reaches the accumulator).
    - Pop with counter==VEC_LEN-1 -> WAIT.
    - Each FEED cycle ORs mac_overflow into the ovf latch.
  - WAIT (one cycle): mac_enable=0. At exit edge: out_result<=mac_result, out_overflow<=ovf_latch|mac_overflow, out_valid<=1. -> HOLD.
  - HOLD: outputs held stable while out_valid && !out_ready. On out_ready: out_valid<=0 at that edge, then:
    - -> CLEAR if FIFO non-empty (judged on pre-edge count).
    - -> IDLE otherwise.
  - FIFO keeps accepting input in every state, including HOLD backpressure.
- mac_a/mac_b are 0 whenever mac_enable=0.
- Latency: first pair pushed into an empty, idle block at edge E0 with pairs continuously available gives out_valid=1 in the cycle after edge E0+VEC_LEN+3.
- Throughput: one vector per VEC_LEN+3 cycles with out_ready tied high.
- VEC_LEN=1: FEED lasts one cycle, then WAIT.

Decomposition:
- Package mac_pkg: DATA_W, ACC_W, state enum (IDLE/CLEAR/FEED/WAIT/HOLD), counter width function $clog2(VEC_LEN+1).
- Sub-module mac_operand_fifo: sync FIFO with parameters DEPTH and W=2*DATA_W; ports push, pop, din, dout, full, empty.
- Top holds the FSM, counter, ovf latch and output register.

Test Plan:
- Basic vector: push (5,3),(2,4),(10,10),(15,2) back-to-back after reset -> one mac_clear pulse, then four mac_enable cycles; out_result=153, out_overflow=0; out_valid rises VEC_LEN+3=7 edges after the first push.
- Stall: gap of 3 cycles between pairs 2 and 3 -> mac_enable low during the gap; counter holds; out_result=153 unchanged.
- Overflow: (255,255)x2 plus (0,0)x2 -> out_overflow=1; out_result equals mac_result sampled in WAIT (64514 for a mod-2^16 accumulator).
- Backpressure: two vectors queued, out_ready=0 for 10 cycles -> first result held stable, FIFO fills to 8 and in_ready=0. After out_ready=1: second vector starts with CLEAR the next cycle; result 153 then second sum.
- Full/simultaneous: FIFO full during FEED with in_valid=1 -> no push while full, push accepted the cycle after a pop; no pair lost or duplicated (scoreboard on mac_a/mac_b sequence).
- Reset mid-FEED after 2 pairs -> next cycle everything at reset values, FIFO empty; a fresh vector then yields the correct sum with no residue.
